// File: rtl/pop_button_conditioner.sv
// pop_button_conditioner: conditions the POP front-panel trim buttons.
// Each channel is synchronised, debounced and edge-detected. The result is
// a one-cycle strobe per accepted press, which feeds the timer's up/down
// duration counters. It also provides a debounced, active-high level.
// Optional build macro POP_BUTTON_AUTOREPEAT_EN: while a button stays held,
// repeat strobes are issued after REPEAT_DELAY and then every REPEAT_PERIOD.
// Bit order: [0] pi/2+, [1] pi/2-, [2] free-precession+, [3] free-precession-.
`timescale 1ns/1ps

module pop_button_channel #(
   parameter int   CNT_WIDTH       = 22,
   parameter int   DEBOUNCE_CYCLES = 50000,
`ifdef POP_BUTTON_AUTOREPEAT_EN
   parameter int   REPEAT_DELAY    = 1250000,
   parameter int   REPEAT_PERIOD   = 250000,
`endif
   parameter logic ACTIVE_LOW      = 1'b1
) (
   input  logic clk_2M5,
   input  logic reset,
   input  logic raw_i,
   output logic pulse_o,
   output logic level_o
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DB_PRESS   = 2'd1,
      HELD       = 2'd2,
      DB_RELEASE = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] DEB_C   = CNT_WIDTH'(DEBOUNCE_CYCLES);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic                 s1_q, s2_q;
   logic                 p;
   state_t               state_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_inc;
   logic                 pulse_q, level_q;

   // Two-flop synchroniser. It resets to the raw "not pressed" value, so
   // leaving reset cannot look like a press edge.
   always_ff @(posedge clk_2M5 or posedge reset) begin
      if (reset) begin
         s1_q <= ACTIVE_LOW;
         s2_q <= ACTIVE_LOW;
      end else begin
         s1_q <= raw_i;
         s2_q <= s1_q;
      end
   end

   // p is 1 while pressed, whatever the pin polarity.
   assign p = s2_q ^ ACTIVE_LOW;

   // Saturating increment. A stuck-held button can never wrap the counter
   // back into a debounce or repeat match.
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;

`ifdef POP_BUTTON_AUTOREPEAT_EN
   localparam logic [CNT_WIDTH-1:0] RD_C = CNT_WIDTH'(REPEAT_DELAY);
   localparam logic [CNT_WIDTH-1:0] RP_C = CNT_WIDTH'(REPEAT_PERIOD);

   logic                 rep_q;
   logic [CNT_WIDTH-1:0] rep_thr;

   // The first repeat waits the long delay; later repeats use the period.
   assign rep_thr = rep_q ? RP_C : RD_C;
`endif

   // Per-channel debounce FSM. Strobe and level are registered here.
   // cnt_q counts stable samples already seen. Acceptance happens on the
   // sample after DEBOUNCE_CYCLES stable ones, which gives the registered
   // output its extra cycle of latency.
   always_ff @(posedge clk_2M5 or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
         level_q <= 1'b0;
`ifdef POP_BUTTON_AUTOREPEAT_EN
         rep_q   <= 1'b0;
`endif
      end else begin
         pulse_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (p) begin
                  state_q <= DB_PRESS;
                  cnt_q   <= CNT_ONE;
               end
            end
            DB_PRESS: begin
               if (!p) begin
                  // Too short to be a press: drop it silently.
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q >= DEB_C) begin
                  state_q <= HELD;
                  cnt_q   <= '0;
                  level_q <= 1'b1;
                  pulse_q <= 1'b1;
`ifdef POP_BUTTON_AUTOREPEAT_EN
                  rep_q   <= 1'b0;
`endif
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            HELD: begin
               if (!p) begin
                  state_q <= DB_RELEASE;
                  cnt_q   <= CNT_ONE;
`ifdef POP_BUTTON_AUTOREPEAT_EN
               end else if (cnt_inc >= rep_thr) begin
                  // Repeat strobe. The threshold is at least 2, so the
                  // strobe can never fall on two cycles in a row.
                  pulse_q <= 1'b1;
                  cnt_q   <= '0;
                  rep_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_inc;
               end
`else
               end else begin
                  cnt_q <= '0;
               end
`endif
            end
            DB_RELEASE: begin
               if (p) begin
                  // Release bounce: still held. Restart the repeat timing
                  // without issuing a strobe.
                  state_q <= HELD;
                  cnt_q   <= '0;
`ifdef POP_BUTTON_AUTOREPEAT_EN
                  rep_q   <= 1'b0;
`endif
               end else if (cnt_q >= DEB_C) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  level_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign pulse_o = pulse_q;
   assign level_o = level_q;

endmodule

module pop_button_conditioner #(
   parameter int   NBUTTONS        = 4,
   parameter int   CNT_WIDTH       = 22,
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter int   REPEAT_DELAY    = 1250000,
   parameter int   REPEAT_PERIOD   = 250000,
   parameter logic ACTIVE_LOW      = 1'b1
) (
   input  logic                clk_2M5,
   input  logic                reset,
   input  logic [NBUTTONS-1:0] btn_raw,
   output logic [NBUTTONS-1:0] btn_pulse,
   output logic [NBUTTONS-1:0] btn_level,
   output logic                any_pulse
);

`ifdef POP_BUTTON_AUTOREPEAT_EN
   localparam int MAX_T1 = (REPEAT_DELAY > DEBOUNCE_CYCLES) ? REPEAT_DELAY : DEBOUNCE_CYCLES;
   localparam int MAX_T  = (REPEAT_PERIOD > MAX_T1) ? REPEAT_PERIOD : MAX_T1;
`else
   localparam int MAX_T  = DEBOUNCE_CYCLES;
`endif

   // Elaboration checks: reject parameter sets the counters cannot honour.
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("pop_button_conditioner: DEBOUNCE_CYCLES must be >= 1");
   end
   if (CNT_WIDTH < $clog2(MAX_T) + 1) begin : g_bad_width
      $error("pop_button_conditioner: CNT_WIDTH too small for timing parameters");
   end
   if (REPEAT_DELAY < 0 || REPEAT_PERIOD < 0) begin : g_bad_repeat_sign
      $error("pop_button_conditioner: REPEAT_* must be non-negative");
   end
`ifdef POP_BUTTON_AUTOREPEAT_EN
   if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_repeat
      $error("pop_button_conditioner: REPEAT_* must be >= 2 so strobes never abut");
   end
`endif

   // One independent conditioner per button. There is no arbitration;
   // the timer resolves a simultaneous plus and minus itself.
   for (genvar i = 0; i < NBUTTONS; i++) begin : g_ch
      pop_button_channel #(
         .CNT_WIDTH       (CNT_WIDTH),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef POP_BUTTON_AUTOREPEAT_EN
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD),
`endif
         .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_ch (
         .clk_2M5 (clk_2M5),
         .reset   (reset),
         .raw_i   (btn_raw[i]),
         .pulse_o (btn_pulse[i]),
         .level_o (btn_level[i])
      );
   end

   // OR of the registered strobes. It lines up cycle-for-cycle with
   // btn_pulse and adds no latency.
   assign any_pulse = |btn_pulse;

endmodule

// File: tb/tb_pop_button_conditioner.sv
// Testbench for pop_button_conditioner. Runs with DEBOUNCE=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8 and active-low buttons. The stimulus pushes expected
// strobes into a scoreboard, and a negedge monitor matches them against the
// DUT's outputs.
`timescale 1ns/1ps

module tb_pop_button_conditioner;

   logic       clk_2M5 = 1'b0;
   logic       reset;
   logic [3:0] btn_raw;
   logic [3:0] btn_pulse;
   logic [3:0] btn_level;
   logic       any_pulse;

   pop_button_conditioner #(
      .NBUTTONS        (4),
      .CNT_WIDTH       (22),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (20),
      .REPEAT_PERIOD   (8),
      .ACTIVE_LOW      (1'b1)
   ) dut (
      .clk_2M5   (clk_2M5),
      .reset     (reset),
      .btn_raw   (btn_raw),
      .btn_pulse (btn_pulse),
      .btn_level (btn_level),
      .any_pulse (any_pulse)
   );

   always #5 clk_2M5 = ~clk_2M5;

   int cyc = 0;
   always @(posedge clk_2M5) cyc <= cyc + 1;

   int n_pass  = 0;
   int n_total = 0;
   bit mon_en  = 1'b0;

   typedef struct {
      int         cyc;
      logic [3:0] vec;
   } exp_t;
   exp_t sb[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic push(input int c, input logic [3:0] v);
      exp_t e;
      e.cyc = c;
      e.vec = v;
      sb.push_back(e);
   endtask

   // Block until the negedge that follows the posedge numbered c.
   task automatic wait_cyc(input int c);
      int guard = 0;
      do begin
         @(negedge clk_2M5);
         guard++;
      end while (cyc < c && guard < 2000);
      if (cyc < c) chk("wait_timeout", cyc, c);
   endtask

   task automatic step();
      @(posedge clk_2M5);
      #1;
   endtask

   // Monitor: every strobe must match the head of the scoreboard.
   always @(negedge clk_2M5) begin
      exp_t e;
      if (mon_en) begin
         if (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("strobe_missing_cycle", cyc, sb[0].cyc);
            void'(sb.pop_front());
         end
         if (btn_pulse !== 4'b0 || any_pulse !== 1'b0) begin
            if (sb.size() == 0) begin
               chk("unexpected_strobe", {27'b0, any_pulse, btn_pulse}, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("strobe_cycle", cyc, e.cyc);
               chk("strobe_vec", {28'b0, btn_pulse}, {28'b0, e.vec});
               chk("any_pulse", {31'b0, any_pulse}, 32'd1);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   int t0, rel, d;

   initial begin
      reset   = 1'b1;
      btn_raw = 4'hF;
      repeat (2) step();
      mon_en = 1'b1;

      // 1: reset with all buttons released, then 10 idle cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_2M5);
         chk("rst_pulse", {28'b0, btn_pulse}, 32'd0);
         chk("rst_level", {28'b0, btn_level}, 32'd0);
         chk("rst_any",   {31'b0, any_pulse}, 32'd0);
      end
      step();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_2M5);
         chk("idle_level", {28'b0, btn_level}, 32'd0);
      end

      // 2: single press on channel 0, strobe 2+4+1 cycles after the edge
      step();
      t0 = cyc;
      btn_raw[0] = 1'b0;
      push(t0 + 7, 4'b0001);
      wait_cyc(t0 + 6);
      chk("ch0_level_pre", {28'b0, btn_level}, 32'd0);
      wait_cyc(t0 + 7);
      chk("ch0_level_acc", {28'b0, btn_level}, 32'd1);
      wait_cyc(t0 + 10);
      step();
      rel = cyc;
      btn_raw[0] = 1'b1;
      wait_cyc(rel + 6);
      chk("ch0_level_rel_pre", {28'b0, btn_level}, 32'd1);
      wait_cyc(rel + 7);
      chk("ch0_level_rel", {28'b0, btn_level}, 32'd0);

      // 3: 3-cycle bounce on channel 2 is rejected
      step();
      t0 = cyc;
      btn_raw[2] = 1'b0;
      wait_cyc(t0 + 2);
      step();
      btn_raw[2] = 1'b1;
      for (int c = t0 + 3; c <= t0 + 12; c++) begin
         wait_cyc(c);
         chk("bounce_level", {28'b0, btn_level}, 32'd0);
      end

      // 4: long hold on channel 1 (auto-repeat depends on build)
      step();
      t0 = cyc;
      btn_raw[1] = 1'b0;
      push(t0 + 7, 4'b0010);
`ifdef POP_BUTTON_AUTOREPEAT_EN
      push(t0 + 27, 4'b0010);
      push(t0 + 35, 4'b0010);
      push(t0 + 43, 4'b0010);
      push(t0 + 51, 4'b0010);
      push(t0 + 59, 4'b0010);
`endif
      wait_cyc(t0 + 30);
      chk("ch1_level_held", {28'b0, btn_level}, 32'd2);
      wait_cyc(t0 + 59);
      step();
      btn_raw[1] = 1'b1;
      wait_cyc(cyc + 8);
      chk("ch1_level_rel", {28'b0, btn_level}, 32'd0);

      // 5: simultaneous press on channels 0 and 3, then a 2-cycle release glitch on ch0
      step();
      t0 = cyc;
      btn_raw = 4'b0110;
      push(t0 + 7, 4'b1001);
      wait_cyc(t0 + 11);
      step();
      btn_raw[0] = 1'b1;
      step();
      step();
      btn_raw[0] = 1'b0;
      for (int c = t0 + 14; c <= t0 + 20; c++) begin
         wait_cyc(c);
         chk("glitch_level", {28'b0, btn_level}, 32'h9);
      end
      step();
      btn_raw = 4'hF;
      wait_cyc(cyc + 8);
      chk("dual_level_rel", {28'b0, btn_level}, 32'd0);

      // 6: reset while channel 2 is mid-debounce (counter 3), with the button still held
      step();
      t0 = cyc;
      btn_raw[2] = 1'b0;
      wait_cyc(t0 + 5);
      reset = 1'b1;
      #1;
      chk("midrst_level", {28'b0, btn_level}, 32'd0);
      chk("midrst_pulse", {28'b0, btn_pulse}, 32'd0);
      step();
      reset = 1'b0;
      d = cyc;
      push(d + 7, 4'b0100);
      wait_cyc(d + 6);
      chk("postrst_level_pre", {28'b0, btn_level}, 32'd0);
      wait_cyc(d + 7);
      chk("postrst_level", {28'b0, btn_level}, 32'd4);
      wait_cyc(d + 10);
      step();
      btn_raw[2] = 1'b1;
      wait_cyc(cyc + 8);
      chk("ch2_level_rel", {28'b0, btn_level}, 32'd0);

      wait_cyc(cyc + 3);
      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
